// File: rtl/env_pkg.sv
// Shared voice-state encoding and envelope level derivations for the envelope bank.
package env_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } vstate_t;

   function automatic longint env_full(input int bits);
      return (longint'(1) << (bits - 1)) - 1;
   endfunction

   // Attack hands over to decay slightly below full scale so tau>0 attacks terminate.
   function automatic longint env_peak(input int bits);
      return env_full(bits) - (env_full(bits) >> 4);
   endfunction

   function automatic longint env_eps(input int bits);
      return (bits >= 12) ? (longint'(1) << (bits - 12)) : longint'(1);
   endfunction

endpackage

// File: rtl/env_step.sv
// One-voice envelope update: gate-driven state change, exponential step toward the
// state's target, saturation and level-based state transitions.
module env_step
   import env_pkg::*;
#(
   parameter int ENV_BITS = 24,
   parameter int TAU_BITS = 5
) (
   input  vstate_t                    i_state,
   input  logic signed [ENV_BITS-1:0] i_env,
   input  logic                       i_gate,
   input  logic [TAU_BITS-1:0]        i_attack_tau,
   input  logic [TAU_BITS-1:0]        i_decay_tau,
   input  logic [TAU_BITS-1:0]        i_release_tau,
   input  logic [ENV_BITS-1:0]        i_sustain_lvl,
   output vstate_t                    o_state,
   output logic signed [ENV_BITS-1:0] o_env
);

   localparam int DW = ENV_BITS + 1;
   localparam int SW = ENV_BITS + 2;

   localparam logic signed [ENV_BITS-1:0] FULL   = ENV_BITS'(env_full(ENV_BITS));
   localparam logic signed [ENV_BITS-1:0] PEAK   = ENV_BITS'(env_peak(ENV_BITS));
   localparam logic        [ENV_BITS-1:0] PEAK_U = ENV_BITS'(env_peak(ENV_BITS));
   localparam logic signed [ENV_BITS-1:0] EPS    = ENV_BITS'(env_eps(ENV_BITS));
   localparam logic signed [DW-1:0]       EPS_D  = DW'(env_eps(ENV_BITS));
   localparam logic signed [SW-1:0]       FULL_S = SW'(env_full(ENV_BITS));

   function automatic logic [TAU_BITS-1:0] clamp_tau(input logic [TAU_BITS-1:0] t);
      if (int'(t) >= ENV_BITS) return TAU_BITS'(ENV_BITS - 1);
      return t;
   endfunction

   function automatic logic signed [ENV_BITS-1:0] sat_env(input logic signed [SW-1:0] v);
      if (v[SW-1])    return '0;
      if (v > FULL_S) return FULL;
      return v[ENV_BITS-1:0];
   endfunction

   vstate_t                    w_state_eff;
   logic signed [ENV_BITS-1:0] w_sus;
   logic signed [ENV_BITS-1:0] w_target;
   logic        [TAU_BITS-1:0] w_tau;
   logic signed [DW-1:0]       w_diff;
   logic signed [DW-1:0]       w_step;
   logic signed [SW-1:0]       w_sum;
   logic signed [ENV_BITS-1:0] w_env_sat;
   logic signed [DW-1:0]       w_err;
   logic signed [DW-1:0]       w_abs;

   always_comb begin
      w_state_eff = i_state;
      if ((i_state == ST_IDLE || i_state == ST_RELEASE) && i_gate)
         w_state_eff = ST_ATTACK;
      else if ((i_state == ST_ATTACK || i_state == ST_DECAY || i_state == ST_SUSTAIN) && !i_gate)
         w_state_eff = ST_RELEASE;

      w_sus = (i_sustain_lvl < PEAK_U) ? i_sustain_lvl : PEAK_U;

      w_target = '0;
      w_tau    = '0;
      case (w_state_eff)
         ST_ATTACK:             begin w_target = FULL;  w_tau = i_attack_tau;  end
         ST_DECAY, ST_SUSTAIN:  begin w_target = w_sus; w_tau = i_decay_tau;   end
         ST_RELEASE:            begin w_target = '0;    w_tau = i_release_tau; end
         default:               begin w_target = '0;    w_tau = '0;            end
      endcase

      w_diff    = DW'(w_target) - DW'(i_env);
      w_step    = w_diff >>> clamp_tau(w_tau);
      w_sum     = SW'(i_env) + SW'(w_step);
      w_env_sat = sat_env(w_sum);
      w_err     = DW'(w_env_sat) - DW'(w_target);
      w_abs     = w_err[DW-1] ? -w_err : w_err;

      o_state = w_state_eff;
      o_env   = w_env_sat;
      case (w_state_eff)
         ST_IDLE:    o_env = '0;
         ST_ATTACK:  if (w_env_sat >= PEAK) o_state = ST_DECAY;
         ST_DECAY:   if (w_abs < EPS_D)     o_state = ST_SUSTAIN;
         ST_RELEASE: if (w_env_sat < EPS) begin
                        o_state = ST_IDLE;
                        o_env   = '0;
                     end
         default:    ;
      endcase
   end

endmodule

// File: rtl/env_bank.sv
// Time-multiplexed ADSR envelope bank: each tick sweeps all voices through one
// shared env_step datapath, one voice per cycle, in index order.
module env_bank
   import env_pkg::*;
#(
   parameter  int VOICES   = 8,
   parameter  int ENV_BITS = 24,
   parameter  int TAU_BITS = 5,
   localparam int VW       = (VOICES > 1) ? $clog2(VOICES) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic [VOICES-1:0]          gate,
   input  logic [TAU_BITS-1:0]        attack_tau,
   input  logic [TAU_BITS-1:0]        decay_tau,
   input  logic [TAU_BITS-1:0]        release_tau,
   input  logic [ENV_BITS-1:0]        sustain_lvl,
   output logic                       env_valid,
   output logic [VW-1:0]              env_voice,
   output logic signed [ENV_BITS-1:0] env_out,
   output logic [VOICES-1:0]          idle,
   output logic                       busy,
   output logic                       overrun
);

   vstate_t                    r_state [VOICES];
   logic signed [ENV_BITS-1:0] r_env   [VOICES];
   logic                       r_busy;
   logic [VW-1:0]              r_slot;
   logic                       r_overrun;

   vstate_t                    w_state_next;
   logic signed [ENV_BITS-1:0] w_env_next;

   env_step #(
      .ENV_BITS (ENV_BITS),
      .TAU_BITS (TAU_BITS)
   ) u_step (
      .i_state       (r_state[r_slot]),
      .i_env         (r_env[r_slot]),
      .i_gate        (gate[r_slot]),
      .i_attack_tau  (attack_tau),
      .i_decay_tau   (decay_tau),
      .i_release_tau (release_tau),
      .i_sustain_lvl (sustain_lvl),
      .o_state       (w_state_next),
      .o_env         (w_env_next)
   );

   // r_slot names the voice owning the datapath this cycle while r_busy is set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy    <= 1'b0;
         r_slot    <= '0;
         r_overrun <= 1'b0;
         for (int k = 0; k < VOICES; k++) begin
            r_state[k] <= ST_IDLE;
            r_env[k]   <= '0;
         end
      end else begin
         r_overrun <= tick & r_busy;
         if (r_busy) begin
            r_state[r_slot] <= w_state_next;
            r_env[r_slot]   <= w_env_next;
            if (r_slot == VW'(VOICES - 1)) begin
               r_busy <= 1'b0;
               r_slot <= '0;
            end else begin
               r_slot <= r_slot + VW'(1);
            end
         end else if (tick) begin
            r_busy <= 1'b1;
            r_slot <= '0;
         end
      end
   end

   always_comb begin
      idle = '0;
      for (int k = 0; k < VOICES; k++)
         idle[k] = (r_state[k] == ST_IDLE);
   end

   assign env_valid = r_busy;
   assign env_voice = r_slot;
   assign env_out   = r_busy ? w_env_next : '0;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_env_bank.sv
// Scoreboard bench for env_bank: a behavioural voice model queues the expected
// output of every slot when a tick is issued; a negedge monitor pops and compares.
module tb_env_bank;

   localparam int NV = 4;
   localparam int EB = 24;
   localparam int TB = 5;
   localparam longint FULL = 64'h7FFFFF;
   localparam longint PEAK = 64'h780000;
   localparam longint EPS  = 64'h1000;
   localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 tick = 1'b0;
   logic [NV-1:0]        gate = '0;
   logic [TB-1:0]        attack_tau = '0, decay_tau = '0, release_tau = '0;
   logic [EB-1:0]        sustain_lvl = '0;
   logic                 env_valid;
   logic [1:0]           env_voice;
   logic signed [EB-1:0] env_out;
   logic [NV-1:0]        idle;
   logic                 busy;
   logic                 overrun;

   env_bank #(.VOICES(NV), .ENV_BITS(EB), .TAU_BITS(TB)) dut (
      .clk(clk), .rst(rst), .tick(tick), .gate(gate),
      .attack_tau(attack_tau), .decay_tau(decay_tau), .release_tau(release_tau),
      .sustain_lvl(sustain_lvl), .env_valid(env_valid), .env_voice(env_voice),
      .env_out(env_out), .idle(idle), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     voice;
      longint env;
   } exp_t;

   exp_t   sb_q[$];
   int     n_vec = 0;
   int     n_err = 0;
   int     cnt_valid = 0, cnt_busy = 0, cnt_ovr = 0;
   longint obs_env [NV];
   int     m_state [NV];
   longint m_env   [NV];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NV; k++) begin
         m_state[k] = S_IDLE;
         m_env[k]   = 0;
      end
   endtask

   task automatic model_step(input int k);
      int     s, tau;
      longint e, tgt;
      s = m_state[k];
      e = m_env[k];
      if ((s == S_IDLE || s == S_REL) && gate[k]) s = S_ATT;
      else if ((s == S_ATT || s == S_DEC || s == S_SUS) && !gate[k]) s = S_REL;
      if (s == S_IDLE) begin
         e = 0;
      end else begin
         if (s == S_ATT) begin
            tgt = FULL; tau = int'(attack_tau);
         end else if (s == S_REL) begin
            tgt = 0; tau = int'(release_tau);
         end else begin
            tgt = (longint'(sustain_lvl) < PEAK) ? longint'(sustain_lvl) : PEAK;
            tau = int'(decay_tau);
         end
         if (tau > EB - 1) tau = EB - 1;
         e = e + ((tgt - e) >>> tau);
         if (e < 0) e = 0;
         if (e > FULL) e = FULL;
         if (s == S_ATT && e >= PEAK) s = S_DEC;
         else if (s == S_DEC && (e - tgt) < EPS && (tgt - e) < EPS) s = S_SUS;
         else if (s == S_REL && e < EPS) begin
            s = S_IDLE;
            e = 0;
         end
      end
      m_state[k] = s;
      m_env[k]   = e;
   endtask

   function automatic logic [NV-1:0] model_idle();
      logic [NV-1:0] v;
      for (int k = 0; k < NV; k++) v[k] = (m_state[k] == S_IDLE);
      return v;
   endfunction

   task automatic push_sweep();
      for (int k = 0; k < NV; k++) begin
         model_step(k);
         sb_q.push_back('{voice: k, env: m_env[k]});
      end
      cnt_valid = 0;
      cnt_busy  = 0;
      cnt_ovr   = 0;
   endtask

   task automatic wait_done();
      int c;
      c = 0;
      while (busy !== 1'b0 && c < NV + 4) begin
         @(posedge clk); #1;
         c++;
      end
      chk("sweep_end", {63'd0, busy}, 64'd0);
   endtask

   task automatic sweep();
      push_sweep();
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      wait_done();
      chk("valid_cycles", cnt_valid, NV);
      chk("busy_cycles", cnt_busy, NV);
      chk("sb_drained", sb_q.size(), 0);
      chk("idle_vec", idle, model_idle());
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (busy === 1'b1)    cnt_busy++;
      if (overrun === 1'b1) cnt_ovr++;
      if (env_valid === 1'b1) begin
         cnt_valid++;
         if (sb_q.size() == 0) begin
            chk("sb_underrun", sb_q.size(), 1);
         end else begin
            e = sb_q.pop_front();
            chk("env_voice", env_voice, e.voice);
            chk("env_out", env_out, e.env);
            obs_env[env_voice] = env_out;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_idle", idle, 4'hF);
      chk("rst_busy", busy, 0);
      chk("rst_valid", env_valid, 0);
      chk("rst_voice", env_voice, 0);
      chk("rst_env", env_out, 0);
      chk("rst_ovr", overrun, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Voice 0 instant attack then decay to sustain
      attack_tau = 0; decay_tau = 0; release_tau = 1;
      sustain_lvl = 24'h200000; gate = 4'b0001;
      sweep();
      chk("v0_attack", obs_env[0], 64'h7FFFFF);
      sweep();
      chk("v0_decay", obs_env[0], 64'h200000);
      sweep();
      chk("v0_sustain", obs_env[0], 64'h200000);

      // Voice 2 to sustain, then a halving release down to idle
      gate = 4'b0101;
      sweep();
      sweep();
      chk("v2_sustain", obs_env[2], 64'h200000);
      gate = 4'b0001;
      for (int i = 0; i < 9; i++) begin
         sweep();
         chk("v2_release", obs_env[2], 64'h100000 >> i);
      end
      sweep();
      chk("v2_to_zero", obs_env[2], 0);
      chk("v2_idle", idle[2], 1);

      // Voice 1 re-attacks from a release level without dropping
      gate = 4'b0011; sustain_lvl = 24'h600000;
      sweep();
      sweep();
      chk("v1_sustain", obs_env[1], 64'h600000);
      chk("v0_new_sus", obs_env[0], 64'h600000);
      gate = 4'b0001;
      sweep();
      chk("v1_release", obs_env[1], 64'h300000);
      gate = 4'b0011; attack_tau = 2;
      sweep();
      chk("v1_reattack", obs_env[1], 64'h43FFFF);

      // Oversized decay shift is clamped to ENV_BITS-1
      decay_tau = 31; sustain_lvl = 24'h200000;
      sweep();
      chk("v0_tau_clamp", obs_env[0], 64'h5FFFFF);

      // Sustain level above PEAK is limited to PEAK
      decay_tau = 0; sustain_lvl = 24'hFFFFFF;
      sweep();
      chk("v0_peak_lim", obs_env[0], 64'h780000);

      // Tick during a sweep is dropped and flagged
      push_sweep();
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      wait_done();
      repeat (2) @(posedge clk);
      #1;
      chk("ovr_pulses", cnt_ovr, 1);
      chk("ovr_valid_cycles", cnt_valid, NV);
      chk("ovr_no_resweep", busy, 0);
      chk("ovr_sb_drained", sb_q.size(), 0);

      // Reset in the middle of a sweep
      push_sweep();
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      sb_q.delete();
      model_reset();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_idle", idle, 4'hF);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_env", env_out, 0);
      chk("mid_rst_valid", env_valid, 0);
      gate = 4'b0010; attack_tau = 0;
      sweep();
      chk("post_rst_v1", obs_env[1], 64'h7FFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
